// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler
// ----------------
// Arbitrates the single register-file write port between the in-order WB
// stage and a long-latency multiply/divide unit (MDU). WB always wins; MDU
// results wait in a small FIFO and drain on cycles where WB is not writing.
// A per-register busy scoreboard tells ID to stall on registers that still
// have an MDU result outstanding, and a starvation counter asks the pipeline
// for a bubble when WB keeps the FIFO head from draining.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   wb_wr/addr/data   WB stage write (cannot be back-pressured)
//   md_issue(_addr)   MDU op issued this cycle and its destination
//   md_valid/addr/data, md_ready
//                     MDU result handshake into the FIFO (md_ready = !full)
//   id_rs/rt/dst      ID stage register operands
//   stall_id          ID operand/destination has a pending MDU write
//   stall_req         pipeline bubble request so the FIFO head can drain
//   rf_wr/addr/data   register-file write port
//   waw_err           sticky: WB wrote a register still pending for the MDU

module rf_wb_scheduler #(
    parameter int DW           = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_wr,
    input  logic [4:0]    wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          md_issue,
    input  logic [4:0]    md_issue_addr,
    input  logic          md_valid,
    output logic          md_ready,
    input  logic [4:0]    md_addr,
    input  logic [DW-1:0] md_data,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [4:0]    id_dst,
    output logic          stall_id,
    output logic          stall_req,
    output logic          rf_wr,
    output logic [4:0]    rf_addr,
    output logic [DW-1:0] rf_data,
    output logic          waw_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic [31:0]   busy_q,   busy_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          waw_q,    waw_d;

    // ------------------------------------------------------------------
    // Derived control
    // ------------------------------------------------------------------
    logic   full, empty, wb_eff, push, pop;
    entry_t head;

    // full is taken from the registered count, so a result offered while
    // full is never accepted even if the head pops in the same cycle.
    assign full   = (count_q == (AW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign head   = mem_q[rd_ptr_q];
    assign wb_eff = wb_wr && (wb_addr != 5'd0);
    assign push   = md_valid && !full;
    // The head slot is consumed whenever WB is quiet, including entries
    // aimed at $0: they burn their slot without reaching the register file.
    assign pop    = !wb_eff && !empty;

    // ------------------------------------------------------------------
    // Write-port mux
    // ------------------------------------------------------------------
    always_comb begin
        rf_wr   = 1'b0;
        rf_addr = head.addr;
        rf_data = head.data;
        if (!reset) begin
            if (wb_eff) begin
                rf_wr   = 1'b1;
                rf_addr = wb_addr;
                rf_data = wb_data;
            end else if (!empty) begin
                rf_wr = (head.addr != 5'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO next state
    // ------------------------------------------------------------------
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{addr: md_addr, data: md_data};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Scoreboard: clear on commit first, then set, so an issue to the same
    // register in the commit cycle leaves it busy.
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head.addr] = 1'b0;
        end
        if (md_issue && (md_issue_addr != 5'd0)) begin
            busy_d[md_issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Starvation counter (saturates at the limit) and WAW detection
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (pop || empty) begin
            cnt_d = '0;
        end else if (wb_eff && (cnt_q < CW'(STARVE_LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
        waw_d = waw_q || (wb_eff && busy_q[wb_addr]);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            cnt_q    <= '0;
            waw_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            waw_q    <= waw_d;
        end
    end

    // Payload storage carries no control meaning, so it is left unreset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign md_ready  = !full;
    assign stall_id  = busy_q[id_rs] | busy_q[id_rt] | busy_q[id_dst];
    assign stall_req = !reset && (cnt_q >= CW'(STARVE_LIMIT));
    assign waw_err   = waw_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
module tb_rf_wb_scheduler;

    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_wr;
    logic [4:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic          md_issue;
    logic [4:0]    md_issue_addr;
    logic          md_valid;
    logic          md_ready;
    logic [4:0]    md_addr;
    logic [DW-1:0] md_data;
    logic [4:0]    id_rs, id_rt, id_dst;
    logic          stall_id, stall_req, rf_wr, waw_err;
    logic [4:0]    rf_addr;
    logic [DW-1:0] rf_data;

    rf_wb_scheduler #(.DW(DW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .wb_wr(wb_wr), .wb_addr(wb_addr), .wb_data(wb_data),
        .md_issue(md_issue), .md_issue_addr(md_issue_addr),
        .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
        .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
        .stall_id(stall_id), .stall_req(stall_req),
        .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data), .waw_err(waw_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        int unsigned addr;
        int unsigned data;
    } res_t;

    res_t q[$];
    bit   busy[32];
    int   starve;
    bit   waw;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        reset = 0; wb_wr = 0; wb_addr = 0; wb_data = 0;
        md_issue = 0; md_issue_addr = 0; md_valid = 0; md_addr = 0; md_data = 0;
        id_rs = 0; id_rt = 0; id_dst = 0;
    endtask

    // Compare every DUT output against the model for the inputs now applied.
    task automatic cmp();
        bit wb_eff;
        bit e_wr;
        int unsigned e_addr, e_data;
        #1;
        wb_eff = wb_wr && (wb_addr != 0);
        e_wr = 0; e_addr = 0; e_data = 0;
        if (!reset) begin
            if (wb_eff) begin
                e_wr = 1; e_addr = wb_addr; e_data = wb_data;
            end else if (q.size() > 0) begin
                e_wr = (q[0].addr != 0); e_addr = q[0].addr; e_data = q[0].data;
            end
        end
        chk("rf_wr", rf_wr, e_wr);
        if (e_wr) begin
            chk("rf_addr", rf_addr, e_addr);
            chk("rf_data", rf_data, e_data);
        end
        chk("stall_req", stall_req, (!reset && starve >= LIMIT));
        if (!reset) begin
            chk("md_ready", md_ready, q.size() < DEPTH);
            chk("stall_id", stall_id, busy[id_rs] || busy[id_rt] || busy[id_dst]);
            chk("waw_err", waw_err, waw);
        end
    endtask

    // Advance one clock and apply the spec's state update rules to the model.
    task automatic tick();
        bit wb_eff, pop, push, was_empty;
        res_t r;
        @(posedge clk);
        if (reset) begin
            q.delete();
            foreach (busy[i]) busy[i] = 0;
            starve = 0;
            waw = 0;
        end else begin
            wb_eff    = wb_wr && (wb_addr != 0);
            was_empty = (q.size() == 0);
            pop       = !wb_eff && !was_empty;
            push      = md_valid && (q.size() < DEPTH);
            if (wb_eff && busy[wb_addr]) waw = 1;
            if (pop || was_empty) starve = 0;
            else if (wb_eff) starve++;
            if (pop) begin
                busy[q[0].addr] = 0;
                void'(q.pop_front());
            end
            if (md_issue && md_issue_addr != 0) busy[md_issue_addr] = 1;
            if (push) begin
                r.addr = md_addr; r.data = md_data;
                q.push_back(r);
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        cmp();
        tick();
    endtask

    initial begin
        starve = 0; waw = 0;
        foreach (busy[i]) busy[i] = 0;
        idle();
        @(negedge clk);

        // 1: reset for two cycles
        reset = 1; step(); reset = 1; step();
        idle(); id_rs = 8; id_rt = 9; id_dst = 31;
        cmp();
        chk("rst_rf_wr", rf_wr, 0);
        chk("rst_md_ready", md_ready, 1);
        chk("rst_stall_id", stall_id, 0);
        chk("rst_waw", waw_err, 0);
        chk("rst_stall_req", stall_req, 0);
        tick();

        // 2: issue $8, result 3 cycles later, commit when WB idle
        idle(); id_rs = 8; md_issue = 1; md_issue_addr = 8; step();
        idle(); id_rs = 8; cmp(); chk("t2_stall_c1", stall_id, 1); tick();
        idle(); id_rs = 8; step();
        idle(); id_rs = 8; md_valid = 1; md_addr = 8; md_data = 32'h1234;
        cmp(); chk("t2_stall_c3", stall_id, 1); tick();
        idle(); id_rs = 8; cmp();
        chk("t2_rf_wr", rf_wr, 1);
        chk("t2_rf_addr", rf_addr, 8);
        chk("t2_rf_data", rf_data, 32'h1234);
        chk("t2_stall_commit", stall_id, 1);
        tick();
        idle(); id_rs = 8; cmp(); chk("t2_stall_after", stall_id, 0); tick();

        // 4: WAW on $9 (left busy on purpose for the reset test)
        idle(); md_issue = 1; md_issue_addr = 9; step();
        idle(); wb_wr = 1; wb_addr = 9; wb_data = 32'hBEEF; cmp();
        chk("t4_wb_write", rf_data, 32'hBEEF); tick();
        idle(); cmp(); chk("t4_waw_set", waw_err, 1); tick();
        idle(); step(); step();
        idle(); cmp(); chk("t4_waw_sticky", waw_err, 1); tick();

        // 3: WB busy every cycle, two results queue, starvation bubble
        idle(); wb_wr = 1; wb_addr = 3; md_valid = 1; md_addr = 10; md_data = 32'hA0; step();
        idle(); wb_wr = 1; wb_addr = 3; md_valid = 1; md_addr = 11; md_data = 32'hB0; step();
        for (int i = 0; i < 3; i++) begin
            idle(); wb_wr = 1; wb_addr = 3; cmp();
            chk("t3_md_ready_full", md_ready, 0);
            chk("t3_no_stall_req", stall_req, 0);
            tick();
        end
        idle(); wb_wr = 1; wb_addr = 3; cmp(); chk("t3_stall_req", stall_req, 1); tick();
        idle(); cmp();
        chk("t3_drain_wr", rf_wr, 1);
        chk("t3_drain_addr", rf_addr, 10);
        chk("t3_drain_data", rf_data, 32'hA0);
        tick();
        idle(); cmp();
        chk("t3_ready_again", md_ready, 1);
        chk("t3_req_clear", stall_req, 0);
        tick();
        idle(); step();

        // 5: result to $0 is popped silently; issue to $0 sets nothing
        idle(); md_valid = 1; md_addr = 0; md_data = 32'h55; step();
        idle(); cmp(); chk("t5_rf_wr0", rf_wr, 0); tick();
        idle(); cmp(); chk("t5_popped", md_ready, 1); tick();
        idle(); md_issue = 1; md_issue_addr = 0; step();
        idle(); cmp(); chk("t5_stall0", stall_id, 0); tick();

        // 6: FIFO full with $8/$9 busy, then one reset cycle
        idle(); md_issue = 1; md_issue_addr = 8; step();
        idle(); wb_wr = 1; wb_addr = 4; md_valid = 1; md_addr = 8; md_data = 1; step();
        idle(); wb_wr = 1; wb_addr = 4; md_valid = 1; md_addr = 9; md_data = 2; step();
        idle(); wb_wr = 1; wb_addr = 4; id_rs = 8; id_rt = 9; cmp();
        chk("t6_full", md_ready, 0); chk("t6_busy", stall_id, 1); tick();
        idle(); reset = 1; cmp(); chk("t6_rst_wr", rf_wr, 0); tick();
        idle(); id_rs = 8; id_rt = 9; cmp();
        chk("t6_ready", md_ready, 1);
        chk("t6_busy_clr", stall_id, 0);
        chk("t6_waw_clr", waw_err, 0);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            idle();
            reset         = ($urandom_range(0, 199) == 0);
            wb_wr         = (starve >= LIMIT) ? 1'b0 : ($urandom_range(0, 99) < 60);
            wb_addr       = 5'($urandom_range(0, 7));
            wb_data       = $urandom;
            md_issue      = ($urandom_range(0, 3) == 0);
            md_issue_addr = 5'($urandom_range(0, 7));
            md_valid      = ($urandom_range(0, 2) == 0);
            md_addr       = 5'($urandom_range(0, 7));
            md_data       = $urandom;
            id_rs         = 5'($urandom_range(0, 7));
            id_rt         = 5'($urandom_range(0, 7));
            id_dst        = 5'($urandom_range(0, 7));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
